// File: rtl/dbus_arbiter_if.sv
// Data-bus bundle between two masters, the arbiter and its targets.
// Carries both master ports plus the RAM, VRAM and status-register sides.
interface dbus_arbiter_if #(
    parameter int RAM_AW  = 8,
    parameter int VRAM_AW = 12
);
    logic                m0_req;
    logic                m0_we;
    logic [31:0]         m0_addr;
    logic [31:0]         m0_wdata;
    logic [31:0]         m0_rdata;
    logic                m0_ack;
    logic                m1_req;
    logic                m1_we;
    logic [31:0]         m1_addr;
    logic [31:0]         m1_wdata;
    logic [31:0]         m1_rdata;
    logic                m1_ack;
    logic [RAM_AW-1:0]   ram_addr;
    logic [31:0]         ram_wdata;
    logic                ram_we;
    logic [31:0]         ram_rdata;
    logic [VRAM_AW-1:0]  vram_waddr;
    logic [7:0]          vram_wdata;
    logic                vram_we;
    logic [15:0]         status;
    logic                bus_err;

    // Arbiter side: sees master requests and RAM read data.
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  ram_rdata,
        output m0_rdata, m0_ack, m1_rdata, m1_ack,
        output ram_addr, ram_wdata, ram_we,
        output vram_waddr, vram_wdata, vram_we,
        output status, bus_err
    );

    // Master/system side: drives requests and RAM read data.
    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output ram_rdata,
        input  m0_rdata, m0_ack, m1_rdata, m1_ack,
        input  ram_addr, ram_wdata, ram_we,
        input  vram_waddr, vram_wdata, vram_we,
        input  status, bus_err
    );
endinterface

// File: rtl/dbus_arbiter.sv
// Two-master data-bus arbiter: round-robin grant, address decode,
// write strobes and read-data return for RAM, VRAM and status reg.
module dbus_arbiter #(
    parameter int RAM_AW  = 8,
    parameter int VRAM_AW = 12
) (
    input  logic           clk,
    input  logic           reset,
    dbus_arbiter_if.slave  bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RDWAIT = 2'd2;

    logic [1:0]  r_state;
    logic        r_last;
    logic        r_sel;
    logic [15:0] r_status;

    logic        w_busy;
    logic        w_msel;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_we;
    logic        w_is_ram;
    logic        w_is_vram;
    logic        w_is_io;
    logic        w_unmap;
    logic        w_acc;
    logic        w_rdw;
    logic        w_ack;
    logic [31:0] w_rdata;
    logic        w_g0;
    logic        w_g1;

    // Target outputs follow master 0 while idle, else the granted one.
    assign w_busy  = (r_state != S_IDLE);
    assign w_msel  = w_busy & r_sel;
    assign w_addr  = w_msel ? bus.m1_addr  : bus.m0_addr;
    assign w_wdata = w_msel ? bus.m1_wdata : bus.m0_wdata;
    assign w_we    = w_msel ? bus.m1_we    : bus.m0_we;

    assign w_is_ram  = (w_addr[31:RAM_AW+2] == '0);
    assign w_is_vram = (w_addr[31:16] == 16'hA000);
    assign w_is_io   = (w_addr == 32'hF000_0000);
    assign w_unmap   = ~(w_is_ram | w_is_vram | w_is_io);

    assign w_acc = (r_state == S_ACCESS);
    assign w_rdw = (r_state == S_RDWAIT);

    // RAM reads are the only ACCESS that defers the ack to RDWAIT.
    assign w_ack = (w_acc & ~(w_is_ram & ~w_we)) | w_rdw;

    always_comb begin
        w_rdata = '0;
        unique case (1'b1)
            w_rdw:                     w_rdata = bus.ram_rdata;
            w_acc & w_is_io & ~w_we:   w_rdata = {16'h0000, r_status};
            default:                   w_rdata = '0;
        endcase
    end

    // Round robin: a lone request wins, a tie goes to !last.
    assign w_g1 = bus.m1_req & (~bus.m0_req | ~r_last);
    assign w_g0 = bus.m0_req & ~w_g1;

    assign bus.ram_addr   = w_addr[RAM_AW+1:2];
    assign bus.ram_wdata  = w_wdata;
    assign bus.ram_we     = w_acc & w_is_ram & w_we;
    assign bus.vram_waddr = w_addr[VRAM_AW+1:2];
    assign bus.vram_wdata = w_wdata[7:0];
    assign bus.vram_we    = w_acc & w_is_vram & w_we;
    assign bus.bus_err    = w_acc & w_unmap;
    assign bus.status     = r_status;

    assign bus.m0_ack   = w_ack & ~r_sel;
    assign bus.m1_ack   = w_ack &  r_sel;
    assign bus.m0_rdata = bus.m0_ack ? w_rdata : '0;
    assign bus.m1_rdata = bus.m1_ack ? w_rdata : '0;

    // Grant / access / read-wait sequencing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
            r_sel   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_g0 | w_g1) begin
                        r_sel   <= w_g1;
                        r_last  <= w_g1;
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (w_is_ram & ~w_we) r_state <= S_RDWAIT;
                    else                  r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Status register write at the edge closing an IO write access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_status <= 16'h0000;
        end else if (w_acc & w_is_io & w_we) begin
            r_status <= w_wdata[15:0];
        end
    end
endmodule

// File: tb/tb_dbus_arbiter.sv
// Testbench for dbus_arbiter: scenario tasks plus an ack scoreboard.
// Expected acks are queued at drive time and popped on each ack.
module tb_dbus_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dbus_arbiter_if #(.RAM_AW(8), .VRAM_AW(12)) bus();

    dbus_arbiter #(.RAM_AW(8), .VRAM_AW(12)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          m;
        logic        chk;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    logic [31:0] mem [0:255];

    // Synchronous RAM model, one-cycle read latency.
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    // Scoreboard: every ack must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        int am;
        logic [31:0] rd;
        logic [31:0] ord;
        if (reset) begin
            checks++;
            if (bus.m0_ack && bus.m1_ack) begin
                errors++;
                $display("FAIL both_ack m0=%0b m1=%0b want one", bus.m0_ack, bus.m1_ack);
            end
            checks++;
            if (bus.ram_we && bus.vram_we) begin
                errors++;
                $display("FAIL both_we ram=%0b vram=%0b", bus.ram_we, bus.vram_we);
            end
            if (bus.m0_ack || bus.m1_ack) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ack m0=%0b m1=%0b want none", bus.m0_ack, bus.m1_ack);
                end else begin
                    e = exp_q.pop_front();
                    am = bus.m1_ack ? 1 : 0;
                    rd = am ? bus.m1_rdata : bus.m0_rdata;
                    ord = am ? bus.m0_rdata : bus.m1_rdata;
                    checks++;
                    if (am !== e.m) begin
                        errors++;
                        $display("FAIL ack_owner got m%0d want m%0d", am, e.m);
                    end
                    checks++;
                    if (bus.bus_err !== e.err) begin
                        errors++;
                        $display("FAIL ack_bus_err got %0b want %0b", bus.bus_err, e.err);
                    end
                    if (e.chk) begin
                        checks++;
                        if (rd !== e.rd) begin
                            errors++;
                            $display("FAIL ack_rdata got %h want %h", rd, e.rd);
                        end
                    end
                    checks++;
                    if (ord !== 32'h0) begin
                        errors++;
                        $display("FAIL idle_rdata got %h want 0", ord);
                    end
                end
            end
        end
    end

    function automatic void push(int m, logic chk, logic [31:0] rd, logic err);
        exp_t e;
        e.m = m;
        e.chk = chk;
        e.rd = rd;
        e.err = err;
        exp_q.push_back(e);
    endfunction

    task automatic set_m(int m, logic req, logic we, logic [31:0] a, logic [31:0] d);
        if (m == 0) begin
            bus.m0_req = req; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = d;
        end else begin
            bus.m1_req = req; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = d;
        end
    endtask

    task automatic wait_ack(int m, output bit got);
        got = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ((m == 0 && bus.m0_ack) || (m == 1 && bus.m1_ack)) begin
                got = 1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        set_m(0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_reset();
        set_m(0, 0, 0, 0, 0);
        set_m(1, 0, 0, 0, 0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.m0_ack !== 1'b0 || bus.m1_ack !== 1'b0) begin
            errors++;
            $display("FAIL rst_ack got %0b%0b want 00", bus.m0_ack, bus.m1_ack);
        end
        checks++;
        if (bus.ram_we !== 1'b0 || bus.vram_we !== 1'b0 || bus.bus_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_strobe got %0b%0b%0b want 000", bus.ram_we, bus.vram_we, bus.bus_err);
        end
        checks++;
        if (bus.status !== 16'h0000) begin
            errors++;
            $display("FAIL rst_status got %h want 0000", bus.status);
        end
        checks++;
        if (bus.m0_rdata !== 32'h0 || bus.m1_rdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_rdata got %h %h want 0", bus.m0_rdata, bus.m1_rdata);
        end
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_ram_write();
        @(posedge clk);
        #1;
        set_m(0, 1, 1, 32'h0000_0010, 32'h1234_5678);
        push(0, 0, 32'h0, 0);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.ram_we !== 1'b1 || bus.vram_we !== 1'b0) begin
            errors++;
            $display("FAIL wr_ram_we got %0b vram %0b want 1 0", bus.ram_we, bus.vram_we);
        end
        checks++;
        if (bus.ram_addr !== 8'd4 || bus.ram_wdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL wr_ram_addr got %h/%h want 04/12345678", bus.ram_addr, bus.ram_wdata);
        end
        checks++;
        if (bus.m0_ack !== 1'b1 || bus.bus_err !== 1'b0) begin
            errors++;
            $display("FAIL wr_ack got ack %0b err %0b want 1 0", bus.m0_ack, bus.bus_err);
        end
        @(posedge clk);
        #1 bus.m0_req = 1'b0;
    endtask

    task automatic test_ram_read();
        set_m(0, 1, 0, 32'h0000_0010, 32'h0);
        push(0, 1, 32'h1234_5678, 0);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.m0_ack !== 1'b0 || bus.ram_we !== 1'b0 || bus.ram_addr !== 8'd4) begin
            errors++;
            $display("FAIL rd_access got ack %0b we %0b addr %h want 0 0 04", bus.m0_ack, bus.ram_we, bus.ram_addr);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.m0_ack !== 1'b1 || bus.m0_rdata !== 32'h1234_5678 || bus.ram_we !== 1'b0) begin
            errors++;
            $display("FAIL rd_data got ack %0b data %h want 1 12345678", bus.m0_ack, bus.m0_rdata);
        end
        @(posedge clk);
        #1 bus.m0_req = 1'b0;
    endtask

    task automatic test_fairness();
        int c0 = 0;
        int c1 = 0;
        int nv = 0;
        do_reset();
        for (int k = 0; k < 8; k++) push(k % 2, 0, 32'h0, 0);
        set_m(0, 1, 1, 32'hA000_0000, 32'd0);
        set_m(1, 1, 1, 32'hA000_0004, 32'd1);
        for (int cyc = 0; cyc < 40 && (c0 < 4 || c1 < 4); cyc++) begin
            @(negedge clk);
            if (bus.vram_we) begin
                checks++;
                if (bus.vram_waddr !== 12'(nv) || bus.vram_wdata !== 8'(nv)) begin
                    errors++;
                    $display("FAIL fair_vram got %h/%h want %h", bus.vram_waddr, bus.vram_wdata, nv);
                end
                nv++;
            end
            if (bus.m0_ack) c0++;
            if (bus.m1_ack) c1++;
            @(posedge clk);
            #1;
            if (c0 >= 4) bus.m0_req = 1'b0;
            else set_m(0, 1, 1, 32'hA000_0000 + 32'(8 * c0), 32'(2 * c0));
            if (c1 >= 4) bus.m1_req = 1'b0;
            else set_m(1, 1, 1, 32'hA000_0004 + 32'(8 * c1), 32'(2 * c1 + 1));
        end
        checks++;
        if (c0 != 4 || c1 != 4 || nv != 8) begin
            errors++;
            $display("FAIL fair_count got %0d/%0d/%0d want 4/4/8", c0, c1, nv);
        end
    endtask

    task automatic test_io();
        bit got;
        set_m(1, 1, 1, 32'hF000_0000, 32'hBEEF_CAFE);
        push(1, 0, 32'h0, 0);
        wait_ack(1, got);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL io_wr_timeout got no ack want ack");
        end
        @(posedge clk);
        #1 bus.m1_req = 1'b0;
        checks++;
        if (bus.status !== 16'hCAFE) begin
            errors++;
            $display("FAIL io_status got %h want cafe", bus.status);
        end
        set_m(1, 1, 0, 32'hF000_0000, 32'h0);
        push(1, 1, 32'h0000_CAFE, 0);
        wait_ack(1, got);
        checks++;
        if (!got || bus.m1_rdata !== 32'h0000_CAFE) begin
            errors++;
            $display("FAIL io_rd got ack %0b data %h want 1 0000cafe", got, bus.m1_rdata);
        end
        @(posedge clk);
        #1 bus.m1_req = 1'b0;
    endtask

    task automatic test_unmapped();
        bit got;
        set_m(0, 1, 1, 32'h5000_0000, 32'hDEAD_BEEF);
        push(0, 0, 32'h0, 1);
        wait_ack(0, got);
        checks++;
        if (!got || bus.bus_err !== 1'b1) begin
            errors++;
            $display("FAIL um_wr got ack %0b err %0b want 1 1", got, bus.bus_err);
        end
        checks++;
        if (bus.ram_we !== 1'b0 || bus.vram_we !== 1'b0) begin
            errors++;
            $display("FAIL um_strobe got %0b%0b want 00", bus.ram_we, bus.vram_we);
        end
        @(posedge clk);
        #1 bus.m0_req = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.bus_err !== 1'b0) begin
            errors++;
            $display("FAIL um_pulse got %0b want 0", bus.bus_err);
        end
        set_m(0, 1, 0, 32'h5000_0000, 32'h0);
        push(0, 1, 32'h0, 1);
        wait_ack(0, got);
        checks++;
        if (!got || bus.m0_rdata !== 32'h0 || bus.bus_err !== 1'b1) begin
            errors++;
            $display("FAIL um_rd got ack %0b data %h err %0b want 1 0 1", got, bus.m0_rdata, bus.bus_err);
        end
        @(posedge clk);
        #1 bus.m0_req = 1'b0;
        checks++;
        if (bus.status !== 16'hCAFE) begin
            errors++;
            $display("FAIL um_status got %h want cafe", bus.status);
        end
    endtask

    task automatic test_reset_mid();
        bit got;
        set_m(1, 1, 0, 32'h0000_0010, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.m1_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.m1_ack !== 1'b0 || bus.m0_ack !== 1'b0) begin
                errors++;
                $display("FAIL mid_ack got %0b%0b want 00", bus.m0_ack, bus.m1_ack);
            end
        end
        checks++;
        if (bus.status !== 16'h0000) begin
            errors++;
            $display("FAIL mid_status got %h want 0000", bus.status);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        set_m(0, 1, 1, 32'h0000_0020, 32'h11);
        set_m(1, 1, 1, 32'h0000_0024, 32'h22);
        push(0, 0, 32'h0, 0);
        push(1, 0, 32'h0, 0);
        wait_ack(0, got);
        checks++;
        if (!got || bus.m1_ack !== 1'b0) begin
            errors++;
            $display("FAIL mid_first got m0 %0b m1 %0b want m0 first", got, bus.m1_ack);
        end
        @(posedge clk);
        #1 bus.m0_req = 1'b0;
        wait_ack(1, got);
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL mid_second got no m1 ack want ack");
        end
        @(posedge clk);
        #1 bus.m1_req = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        bus.ram_rdata = 32'h0;
        test_reset();
        test_ram_write();
        test_ram_read();
        test_fairness();
        test_io();
        test_unmapped();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_left got %0d pending want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dbus_arbiter.md
Name: dbus_arbiter

Overview:
- Shares the single data-side target set (word RAM, video RAM write port, status register) between two bus masters.
  - m0 is the cpu32 data port.
  - m1 is a secondary master, e.g. a fill/scroll DMA engine.
- Performs address decode, round-robin arbitration, write strobing and read-data return with a req/ack handshake.
- Sits between the masters and the syncram, videoram and hex-display status register in the board top level.

Parameters:
- RAM_AW, 8: RAM word-address width; RAM window is byte addresses 0 .. 4*2^RAM_AW-1.
- VRAM_AW, 12: VRAM write-address width; vram_waddr = addr[VRAM_AW+1:2].

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset (0 = in reset)
- m0_req  input  1  master 0 request
- m0_we  input  1  master 0 write (1) / read (0)
- m0_addr  input  32  master 0 byte address
- m0_wdata  input  32  master 0 write data
- m0_rdata  output  32  master 0 read data, valid when m0_ack=1
- m0_ack  output  1  master 0 completion pulse
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack: as m0 for master 1
- ram_addr  output  RAM_AW  RAM word address
- ram_wdata  output  32  RAM write data
- ram_we  output  1  RAM write strobe
- ram_rdata  input  32  RAM read data, 1-cycle synchronous latency
- vram_waddr  output  VRAM_AW  VRAM write address
- vram_wdata  output  8  VRAM write data = wdata[7:0]
- vram_we  output  1  VRAM write strobe
- status  output  16  status register, drives the hex display
- bus_err  output  1  one-cycle pulse with the ack of an unmapped access

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, last=1 (m0 wins the first tie).
  - All acks, strobes and bus_err = 0; status = 16'h0000; rdata outputs = 0.
  - Reset mid-access abandons it: no ack and no strobe after release.
- Decode, from the selected master's addr:
  - RAM if addr[31:RAM_AW+2]==0.
  - VRAM if addr[31:16]==16'hA000.
  - IO if addr==32'hF000_0000.
  - Otherwise unmapped.
- FSM states: IDLE, ACCESS, RDWAIT.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant !last.
  - On grant: latch sel, set last=sel, go to ACCESS.
  - No request: stay in IDLE.
- ACCESS, one cycle; target outputs are driven combinationally from the selected master's addr/wdata.
  - RAM write: ram_we=1, ack, go to IDLE.
  - RAM read: ram_addr presented, no ack, go to RDWAIT.
  - VRAM write: vram_we=1, ack, go to IDLE.
  - VRAM read: write-only target; rdata=0, ack, go to IDLE.
  - IO write: status <= wdata[15:0] at the clock edge ending ACCESS; ack.
  - IO read: rdata={16'h0,status}, ack.
  - Unmapped: no strobe; rdata=0; ack with bus_err=1.
- RDWAIT: rdata=ram_rdata, ack, go to IDLE.
- Latency from req seen in IDLE:
  - write ack at cycle +1;
  - RAM read ack at cycle +2;
  - the next grant can be no earlier than the cycle after ack.
- Handshake rules:
  - A master holds req/we/addr/wdata stable until it sees ack.
  - ack is a single-cycle pulse.
  - The master may keep req high to issue a back-to-back access; it is re-arbitrated in IDLE.
  - The unselected master's ack stays 0; its rdata holds 0.
  - Dropping req before ack is illegal; the access completes regardless.
- Strobes: ram_we and vram_we are never high outside ACCESS and never both high. ram_addr/ram_wdata follow the selected master while not IDLE, and master 0 in IDLE.
- Fairness: with both reqs held continuously, grants alternate m0, m1, m0, ...; neither master waits more than one foreign access.

Test Plan:
- Reset, then m0 writes 32'h1234_5678 to 0x0000_0010 -> ram_we=1, ram_addr=4 in the cycle after req; m0_ack same cycle; bus_err=0.
- m0 reads 0x0000_0010 with RAM returning 32'h1234_5678 -> ack 2 cycles after req, m0_rdata=32'h1234_5678; ram_we stays 0.
- m0 and m1 both request from reset, holding req for 4 accesses each (writes to 0xA000_0000+4k, wdata=k) -> grant order m0,m1,m0,m1,...; vram_waddr=k, vram_wdata=k; each ack appears only to its owner.
- m1 writes 32'hBEEF_CAFE to 0xF000_0000, then reads it back -> status=16'hCAFE after write ack; read returns 32'h0000_CAFE.
- m0 accesses 0x5000_0000, write then read -> ack with bus_err=1 for one cycle each; no ram_we/vram_we; read data 0; status unchanged.
- Assert reset=0 during RDWAIT of an m1 read -> no m1_ack; after release state is IDLE, status=0; a simultaneous request pair is granted to m0 first.
